// File: rtl/adder_seq_ctrl.sv
// Wide add/subtract built from one shared 4-bit ripple adder, one nibble per clock,
// least-significant nibble first, with a registered carry between steps.
`timescale 1ns/1ps

module adder4B (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);

  always_comb begin : ripple
    logic [4:0] c;
    c    = '0;
    s_o  = '0;
    c[0] = ci_i;
    for (int unsigned i = 0; i < 4; i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    co_o = c[4];
  end

endmodule

module adder_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   overflow
);

  localparam int unsigned WIDTH = 4 * NIBBLES;
  localparam int unsigned IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] nib_a, nib_b, nib_s;
  logic       nib_co;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (idx_q == IDXW'(k)) begin
        nib_a = a_q[4*k +: 4];
        nib_b = b_q[4*k +: 4];
      end
    end
  end

  adder4B u_adder4B (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .ci_i (carry_q),
    .s_o  (nib_s),
    .co_o (nib_co)
  );

  // b_q holds the effective operand (already inverted for subtract), so the
  // RUN path is a plain add and the overflow sign test uses b_q directly.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = sub ? ~b : b;
          carry_d  = cin ^ sub;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          idx_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        for (int unsigned k = 0; k < NIBBLES; k++) begin
          if (idx_q == IDXW'(k)) begin
            result_d[4*k +: 4] = nib_s;
          end
        end
        carry_d = nib_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = nib_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[3] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
